// File: rtl/dom_pkg.sv
// Shared helpers for the DOM-indep AND pipeline: pair enumeration and randomness sizing.
package dom_pkg;
  localparam int RAND_FRESH  = 0;
  localparam int RAND_SHARED = 1;  // deliberately insecure: every pair reuses slice 0

  function automatic int rand_words(input int d);
    return d * (d + 1) / 2;
  endfunction

  // Row-major index of pair (i,j), i<j: (0,1)=0, (0,2)=1, ..., (d-1,d)=R-1
  function automatic int pair_index(input int i, input int j, input int d);
    return i * d - (i * (i - 1)) / 2 + (j - i - 1);
  endfunction
endpackage

// File: rtl/dom_pipe_stage.sv
// One valid/data register slice; loads on en, synchronous active-low reset.
module dom_pipe_stage #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/dom_and_pipe.sv
// Pipelined DOM-indep masked AND of order D over W-bit shares with valid/ready flow control.
module dom_and_pipe
  import dom_pkg::*;
#(
  parameter int D         = 1,
  parameter int W         = 1,
  parameter int OUT_REG   = 0,
  parameter int RAND_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [(D+1)*W-1:0]           port_a,
  input  logic [(D+1)*W-1:0]           port_b,
  input  logic [(D*(D+1)/2)*W-1:0]     port_r,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(D+1)*W-1:0]           port_c
);
  localparam int S  = D + 1;
  localparam int TW = S * S * W;

  // Term (k,j) lives at [(k*S+j)*W +: W]; the diagonal carries the inner product a_k&b_k.
  logic [TW-1:0]  terms;
  logic [TW-1:0]  s1_q;
  logic           s1_valid;
  logic           s1_en;
  logic [S*W-1:0] comp;

  genvar gi, gj;
  generate
    for (gi = 0; gi < S; gi++) begin : g_row
      for (gj = 0; gj < S; gj++) begin : g_col
        if (gi == gj) begin : g_inner
          assign terms[(gi*S+gj)*W +: W] = port_a[gi*W +: W] & port_b[gi*W +: W];
        end else begin : g_cross
          localparam int LO = (gi < gj) ? gi : gj;
          localparam int HI = (gi < gj) ? gj : gi;
          localparam int P  = (RAND_MODE == RAND_SHARED) ? 0 : pair_index(LO, HI, D);
          assign terms[(gi*S+gj)*W +: W] =
            (port_a[gi*W +: W] & port_b[gj*W +: W]) ^ port_r[P*W +: W];
        end
      end
    end
  endgenerate

  dom_pipe_stage #(.DW(TW)) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (s1_en),
    .in_valid (in_valid),
    .in_data  (terms),
    .out_valid(s1_valid),
    .out_data (s1_q)
  );

  // Domain compression only ever sees registered terms.
  always_comb begin
    comp = '0;
    for (int k = 0; k < S; k++)
      for (int j = 0; j < S; j++)
        comp[k*W +: W] = comp[k*W +: W] ^ s1_q[(k*S+j)*W +: W];
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic s2_en;
      assign s2_en = !out_valid || out_ready;
      assign s1_en = !s1_valid || s2_en;
      dom_pipe_stage #(.DW(S*W)) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (s2_en),
        .in_valid (s1_valid),
        .in_data  (comp),
        .out_valid(out_valid),
        .out_data (port_c)
      );
    end else begin : g_out_comb
      assign s1_en     = !s1_valid || out_ready;
      assign out_valid = s1_valid;
      assign port_c    = comp;
    end
  endgenerate

  assign in_ready = s1_en;
endmodule

// File: tb/tb_dom_and_pipe.sv
// Scoreboard bench: D=2,W=8 in fresh/no-out-reg and shared-random/out-reg configurations.
module tb_dom_and_pipe;
  localparam int D = 2, W = 8, S = 3, SW = 24;

  typedef struct packed {
    logic [SW-1:0] c;
    logic [W-1:0]  u;
  } exp_t;

  logic          clk, rst_n, in_valid, out_ready;
  logic [SW-1:0] a, b, r;
  logic [1:0]    rdy, ov;
  logic [SW-1:0] c0, c1;

  int   nvec = 0, nerr = 0;
  int   acc[2];
  exp_t sb[2][$];
  logic hold[2];
  logic [SW-1:0] hold_c[2];

  dom_and_pipe #(.D(D), .W(W), .OUT_REG(0), .RAND_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .port_a(a), .port_b(b), .port_r(r),
    .out_valid(ov[0]), .out_ready(out_ready), .port_c(c0));

  dom_and_pipe #(.D(D), .W(W), .OUT_REG(1), .RAND_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .port_a(a), .port_b(b), .port_r(r),
    .out_valid(ov[1]), .out_ready(out_ready), .port_c(c1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each share pair (i<j) draws one random word in row-major order; mode 1 reuses word 0.
  function automatic exp_t model(input logic [SW-1:0] av, bv, rv, input int mode);
    logic [W-1:0] x[S][S];
    logic [W-1:0] rw, ua, ub;
    exp_t e;
    int p;
    p = 0;
    for (int i = 0; i < S; i++) x[i][i] = av[i*W +: W] & bv[i*W +: W];
    for (int i = 0; i < S; i++)
      for (int j = i + 1; j < S; j++) begin
        rw = (mode == 1) ? rv[W-1:0] : rv[p*W +: W];
        x[i][j] = (av[i*W +: W] & bv[j*W +: W]) ^ rw;
        x[j][i] = (av[j*W +: W] & bv[i*W +: W]) ^ rw;
        p++;
      end
    e.c = '0;
    for (int k = 0; k < S; k++)
      for (int j = 0; j < S; j++) e.c[k*W +: W] = e.c[k*W +: W] ^ x[k][j];
    ua = av[7:0] ^ av[15:8] ^ av[23:16];
    ub = bv[7:0] ^ bv[15:8] ^ bv[23:16];
    e.u = ua & ub;
    return e;
  endfunction

  // Stimulus side: record every accepted transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb[0].delete();
      sb[1].delete();
    end else begin
      if (in_valid && rdy[0]) begin sb[0].push_back(model(a, b, r, 0)); acc[0]++; end
      if (in_valid && rdy[1]) begin sb[1].push_back(model(a, b, r, 1)); acc[1]++; end
    end
  end

  task automatic check_port(input int id, input logic v, input logic [SW-1:0] cv);
    exp_t e;
    if (hold[id]) begin
      cmp($sformatf("u%0d hold_valid", id), {31'b0, v}, 32'd1);
      cmp($sformatf("u%0d hold_data", id), {8'b0, cv}, {8'b0, hold_c[id]});
    end
    if (v && out_ready) begin
      if (sb[id].size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL u%0d stale_word: got %h expected no output", id, cv);
      end else begin
        e = sb[id].pop_front();
        cmp($sformatf("u%0d port_c", id), {8'b0, cv}, {8'b0, e.c});
        cmp($sformatf("u%0d unmasked", id), {24'b0, cv[7:0] ^ cv[15:8] ^ cv[23:16]}, {24'b0, e.u});
      end
    end
    hold[id]   = v && !out_ready;
    hold_c[id] = cv;
  endtask

  // Monitor side: compare whatever the DUTs present.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      check_port(0, ov[0], c0);
      check_port(1, ov[1], c1);
    end
  end

  task automatic rand_in();
    a = SW'($urandom);
    b = SW'($urandom);
    r = SW'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    cmp("rst out_valid0", {31'b0, ov[0]}, 32'd0);
    cmp("rst out_valid1", {31'b0, ov[1]}, 32'd0);
    cmp("rst port_c0", {8'b0, c0}, 32'd0);
    cmp("rst port_c1", {8'b0, c1}, 32'd0);
    rst_n = 1'b1;
    cmp("rst in_ready0", {31'b0, rdy[0]}, 32'd1);
    cmp("rst in_ready1", {31'b0, rdy[1]}, 32'd1);
  endtask

  initial begin
    int s0, s1;
    logic [SW-1:0] pa, pb;
    acc[0] = 0; acc[1] = 0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    a = '0; b = '0; r = '0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    do_reset(2);

    // Directed: r slices 0x3C,0xA5,0x0F; latency and shared-randomness probe
    rand_in();
    r = 24'h0FA53C;
    pa = a; pb = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp("lat1 out_valid0", {31'b0, ov[0]}, 32'd1);
    cmp("lat1 out_valid1", {31'b0, ov[1]}, 32'd0);
    cmp("probe m0 x02", {24'b0, dut0.s1_q[16 +: 8]}, {24'b0, (pa[7:0] & pb[23:16]) ^ 8'hA5});
    cmp("probe m0 x12", {24'b0, dut0.s1_q[40 +: 8]}, {24'b0, (pa[15:8] & pb[23:16]) ^ 8'h0F});
    cmp("probe m1 x02", {24'b0, dut1.s1_q[16 +: 8]}, {24'b0, (pa[7:0] & pb[23:16]) ^ 8'h3C});
    cmp("probe m1 x20", {24'b0, dut1.s1_q[48 +: 8]}, {24'b0, (pa[23:16] & pb[7:0]) ^ 8'h3C});
    cmp("probe m1 x12", {24'b0, dut1.s1_q[40 +: 8]}, {24'b0, (pa[15:8] & pb[23:16]) ^ 8'h3C});
    cmp("probe m1 x21", {24'b0, dut1.s1_q[56 +: 8]}, {24'b0, (pa[23:16] & pb[15:8]) ^ 8'h3C});
    @(posedge clk); #1;
    cmp("lat2 out_valid1", {31'b0, ov[1]}, 32'd1);
    repeat (2) @(posedge clk); #1;

    // Back-to-back full-throughput stream
    s0 = acc[0]; s1 = acc[1];
    in_valid = 1'b1;
    for (int n = 0; n < 256; n++) begin
      rand_in();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cmp("throughput0", acc[0] - s0, 32'd256);
    cmp("throughput1", acc[1] - s1, 32'd256);
    repeat (3) @(posedge clk); #1;

    // Stall with continuous offer
    s0 = acc[0]; s1 = acc[1];
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      rand_in();
      @(posedge clk); #1;
    end
    cmp("stall accepts0", acc[0] - s0, 32'd1);
    cmp("stall accepts1", acc[1] - s1, 32'd2);
    cmp("stall in_ready0", {31'b0, rdy[0]}, 32'd0);
    cmp("stall in_ready1", {31'b0, rdy[1]}, 32'd0);
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      rand_in();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset with words in flight
    in_valid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      rand_in();
      @(posedge clk); #1;
    end
    do_reset(1);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      cmp("post-rst idle0", {31'b0, ov[0]}, 32'd0);
      cmp("post-rst idle1", {31'b0, ov[1]}, 32'd0);
    end

    // out_ready toggling under a continuous stream
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      rand_in();
      out_ready = n[0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && (sb[0].size() != 0 || sb[1].size() != 0); t++) @(posedge clk);
    #1;
    cmp("drain0", sb[0].size(), 32'd0);
    cmp("drain1", sb[1].size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
